// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
//   Control bundle between the multicycle control FSM and the datapath/DBU.
//   master modport: the control FSM (drives controls, state, instr_cnt;
//                   samples run, op, zero).
//   slave modport : the datapath/DBU side (the mirror image).
//   Signals:
//     run        DBU run enable (0 freezes the FSM)
//     op         opcode, IR[31:26]
//     zero       ALU zero flag
//     pc_we      PC write enable
//     pc_src     next-PC select: 00 ALU, 01 ALUOut, 10 jump target
//     iord       memory address select: 0 PC, 1 ALUOut
//     mem_we     memory write enable
//     ir_we      instruction register write enable
//     reg_dst    write register select: 0 rt, 1 rd
//     mem_to_reg write data select: 0 ALUOut, 1 MDR
//     reg_we     register file write enable
//     alu_src_a  ALU A select: 0 PC, 1 register A
//     alu_src_b  ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//     alu_op     ALU op class: 00 add, 01 sub, 10 funct
//     state      current FSM state
//     instr_cnt  retired-instruction count
interface mc_control_fsm_if;
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        iord;
    logic        mem_we;
    logic        ir_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_we;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    modport master (
        input  run, op, zero,
        output pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_op, state, instr_cnt
    );

    modport slave (
        output run, op, zero,
        input  pc_we, pc_src, iord, mem_we, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_op, state, instr_cnt
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multicycle control unit for the MIPS-subset CPU. Moore FSM, one state
//   per cycle; the only Mealy term is pc_we = zero in the BEQ state.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset (state=IF, instr_cnt=0)
//     bus  mc_control_fsm_if.master: run/op/zero in, datapath controls,
//          state and instr_cnt out
//   Write enables (pc_we, mem_we, ir_we, reg_we) are suppressed while rst
//   is high or run is low; select outputs always decode the current state.
module mc_control_fsm #(
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_J    = 6'b000010,
    parameter logic [5:0] OP_ADDI = 6'b001000
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_control_fsm_if.master     bus
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_MWB = 4'd4,
        S_MW  = 4'd5,
        S_EXR = 4'd6,
        S_RWB = 4'd7,
        S_BEQ = 4'd8,
        S_J   = 4'd9,
        S_EXI = 4'd10,
        S_IWB = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic        pc_we_raw, mem_we_raw, ir_we_raw, reg_we_raw;
    logic        we_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else if (bus.run) begin
            state_q <= state_d;
            // Retire on every return to IF, including the illegal-op ID->IF path.
            if (state_d == S_IF && state_q != S_IF)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d        = S_IF;
        pc_we_raw      = 1'b0;
        mem_we_raw     = 1'b0;
        ir_we_raw      = 1'b0;
        reg_we_raw     = 1'b0;
        bus.pc_src     = 2'b00;
        bus.iord       = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        case (state_q)
            S_IF: begin
                ir_we_raw     = 1'b1;
                pc_we_raw     = 1'b1;
                bus.alu_src_b = 2'b01;
                state_d       = S_ID;
            end
            S_ID: begin
                bus.alu_src_b = 2'b11;
                if (bus.op == OP_LW || bus.op == OP_SW) state_d = S_MA;
                else if (bus.op == OP_R)                state_d = S_EXR;
                else if (bus.op == OP_BEQ)              state_d = S_BEQ;
                else if (bus.op == OP_J)                state_d = S_J;
                else if (bus.op == OP_ADDI)             state_d = S_EXI;
                else                                    state_d = S_IF;
            end
            S_MA: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.op == OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                bus.iord = 1'b1;
                state_d  = S_MWB;
            end
            S_MWB: begin
                reg_we_raw     = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MW: begin
                bus.iord   = 1'b1;
                mem_we_raw = 1'b1;
            end
            S_EXR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_RWB;
            end
            S_RWB: begin
                reg_we_raw  = 1'b1;
                bus.reg_dst = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                pc_we_raw     = bus.zero;
            end
            S_J: begin
                bus.pc_src = 2'b10;
                pc_we_raw  = 1'b1;
            end
            S_EXI: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_IWB;
            end
            S_IWB: begin
                reg_we_raw = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    assign we_ok         = bus.run & ~rst;
    assign bus.pc_we     = pc_we_raw  & we_ok;
    assign bus.mem_we    = mem_we_raw & we_ok;
    assign bus.ir_we     = ir_we_raw  & we_ok;
    assign bus.reg_we    = reg_we_raw & we_ok;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Directed bench for mc_control_fsm: walks each instruction class through
//   its state sequence, checks per-state controls, run freeze and async reset.
module tb_mc_control_fsm;

    logic clk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    mc_control_fsm_if bus ();

    mc_control_fsm #(
        .OP_R    (6'b000000),
        .OP_LW   (6'b100011),
        .OP_SW   (6'b101011),
        .OP_BEQ  (6'b000100),
        .OP_J    (6'b000010),
        .OP_ADDI (6'b001000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_state(input string tag, input logic [3:0] exp);
        step();
        check(tag, {28'd0, bus.state}, {28'd0, exp});
    endtask

    function automatic logic [3:0] wes();
        return {bus.pc_we, bus.mem_we, bus.ir_we, bus.reg_we};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.op   = 6'b000000;
        bus.zero = 1'b0;
        #12;
        bus.run = 1'b1;
        #1;
        check("rst_state", {28'd0, bus.state}, 32'd0);
        check("rst_cnt", bus.instr_cnt, 32'd0);
        check("rst_wes", {28'd0, wes()}, 32'd0);
        check("rst_alub", {30'd0, bus.alu_src_b}, 32'd1);
        rst = 1'b0;
        #1;
        check("if_wes", {28'd0, wes()}, 32'b1010);

        // R-type: 0,1,6,7,0
        bus.op = 6'b000000;
        step_state("r_id", 4'd1);
        check("r_id_wes", {28'd0, wes()}, 32'd0);
        check("r_id_alub", {30'd0, bus.alu_src_b}, 32'd3);
        step_state("r_exr", 4'd6);
        check("r_exr_alu", {29'd0, bus.alu_src_a, bus.alu_src_b}, 32'b100);
        check("r_exr_op", {30'd0, bus.alu_op}, 32'd2);
        step_state("r_rwb", 4'd7);
        check("r_rwb_wes", {28'd0, wes()}, 32'b0001);
        check("r_rwb_dst", {31'd0, bus.reg_dst}, 32'd1);
        step_state("r_if", 4'd0);
        check("r_cnt", bus.instr_cnt, 32'd1);

        // LW: 0,1,2,3,4,0
        bus.op = 6'b100011;
        step_state("lw_id", 4'd1);
        step_state("lw_ma", 4'd2);
        check("lw_ma_alu", {29'd0, bus.alu_src_a, bus.alu_src_b}, 32'b110);
        step_state("lw_mr", 4'd3);
        check("lw_mr_iord", {31'd0, bus.iord}, 32'd1);
        check("lw_mr_wes", {28'd0, wes()}, 32'd0);
        step_state("lw_mwb", 4'd4);
        check("lw_mwb_wes", {28'd0, wes()}, 32'b0001);
        check("lw_mwb_m2r", {30'd0, bus.mem_to_reg, bus.reg_dst}, 32'b10);
        step_state("lw_if", 4'd0);
        check("lw_cnt", bus.instr_cnt, 32'd2);

        // SW: 0,1,2,5,0
        bus.op = 6'b101011;
        step_state("sw_id", 4'd1);
        step_state("sw_ma", 4'd2);
        check("sw_ma_memwe", {31'd0, bus.mem_we}, 32'd0);
        step_state("sw_mw", 4'd5);
        check("sw_mw_wes", {28'd0, wes()}, 32'b0100);
        check("sw_mw_iord", {31'd0, bus.iord}, 32'd1);
        step_state("sw_if", 4'd0);
        check("sw_cnt", bus.instr_cnt, 32'd3);

        // BEQ taken / not taken
        bus.op = 6'b000100;
        bus.zero = 1'b1;
        step_state("beq1_id", 4'd1);
        step_state("beq1_beq", 4'd8);
        check("beq1_pcwe", {31'd0, bus.pc_we}, 32'd1);
        check("beq1_pcsrc", {30'd0, bus.pc_src}, 32'd1);
        check("beq1_aluop", {30'd0, bus.alu_op}, 32'd1);
        step_state("beq1_if", 4'd0);
        bus.zero = 1'b0;
        step_state("beq0_id", 4'd1);
        step_state("beq0_beq", 4'd8);
        check("beq0_pcwe", {31'd0, bus.pc_we}, 32'd0);
        step_state("beq0_if", 4'd0);
        check("beq_cnt", bus.instr_cnt, 32'd5);

        // J
        bus.op = 6'b000010;
        step_state("j_id", 4'd1);
        step_state("j_j", 4'd9);
        check("j_pcsrc", {30'd0, bus.pc_src}, 32'd2);
        check("j_wes", {28'd0, wes()}, 32'b1000);
        step_state("j_if", 4'd0);
        check("j_cnt", bus.instr_cnt, 32'd6);

        // Illegal opcode: 0,1,0
        bus.op = 6'b111111;
        step_state("ill_id", 4'd1);
        check("ill_wes", {28'd0, wes()}, 32'd0);
        step_state("ill_if", 4'd0);
        check("ill_cnt", bus.instr_cnt, 32'd7);

        // Run freeze in MW
        bus.op = 6'b101011;
        step_state("frz_id", 4'd1);
        step_state("frz_ma", 4'd2);
        step_state("frz_mw", 4'd5);
        bus.run = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("frz_memwe", {31'd0, bus.mem_we}, 32'd0);
            check("frz_iord", {31'd0, bus.iord}, 32'd1);
            step_state("frz_hold", 4'd5);
        end
        check("frz_cnt", bus.instr_cnt, 32'd7);
        bus.run = 1'b1;
        #1;
        check("frz_resume_memwe", {31'd0, bus.mem_we}, 32'd1);
        step_state("frz_if", 4'd0);
        check("frz_if_memwe", {31'd0, bus.mem_we}, 32'd0);
        check("frz_cnt2", bus.instr_cnt, 32'd8);

        // Async reset mid-EXR
        bus.op = 6'b000000;
        step_state("ar_id", 4'd1);
        step_state("ar_exr", 4'd6);
        #2;
        rst = 1'b1;
        #1;
        check("ar_state", {28'd0, bus.state}, 32'd0);
        check("ar_cnt", bus.instr_cnt, 32'd0);
        check("ar_wes", {28'd0, wes()}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step_state("ar_hold", 4'd0);
            check("ar_hold_wes", {28'd0, wes()}, 32'd0);
        end
        rst = 1'b0;
        #1;

        // ADDI after reset: 0,1,10,11,0
        bus.op = 6'b001000;
        step_state("ai_id", 4'd1);
        step_state("ai_exi", 4'd10);
        check("ai_exi_alu", {29'd0, bus.alu_src_a, bus.alu_src_b}, 32'b110);
        step_state("ai_iwb", 4'd11);
        check("ai_iwb_wes", {28'd0, wes()}, 32'b0001);
        check("ai_iwb_sel", {30'd0, bus.reg_dst, bus.mem_to_reg}, 32'd0);
        step_state("ai_if", 4'd0);
        check("ai_cnt", bus.instr_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
